// File: rtl/ram1m_pkg.sv
// Shared encodings for the 1MB expansion SRAM fill engine: FSM states,
// config register indices, command bits and default geometry.
package ram1m_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_HOLD  = 3'd4
    } fill_state_t;

    localparam logic [2:0] REG_FILL = 3'd0;
    localparam logic [2:0] REG_BLK  = 3'd1;
    localparam logic [2:0] REG_PAGE = 3'd2;
    localparam logic [2:0] REG_LEN  = 3'd3;
    localparam logic [2:0] REG_CMD  = 3'd4;

    localparam int CMD_START = 0;
    localparam int CMD_ABORT = 1;
    localparam int CMD_INC   = 2;

    localparam logic [3:0] SHADOW_BANK_DEF = 4'b0111;
    localparam int         LEN_W_DEF       = 6;

endpackage

// File: rtl/fill_addr_ctr.sv
// Address / remaining-byte counter pair for the fill engine. The zero flag
// marks the byte whose step brings the remaining count to zero.
module fill_addr_ctr #(
    parameter int ADR_W = 14,
    parameter int REM_W = 15
) (
    input  logic             clk,
    input  logic             reset_b_w,
    input  logic             load,
    input  logic             step,
    input  logic [ADR_W-1:0] load_adr,
    input  logic [REM_W-1:0] load_rem,
    output logic [ADR_W-1:0] adr,
    output logic             zero
);

    logic [ADR_W-1:0] adr_reg;
    logic [REM_W-1:0] rem_reg;

    always_ff @(posedge clk or negedge reset_b_w) begin
        if (!reset_b_w) begin
            adr_reg <= '0;
            rem_reg <= '0;
        end else if (load) begin
            adr_reg <= load_adr;
            rem_reg <= load_rem;
        end else if (step) begin
            // Address wraps naturally inside the 16KB block.
            adr_reg <= adr_reg + ADR_W'(1);
            rem_reg <= rem_reg - REM_W'(1);
        end
    end

    assign adr  = adr_reg;
    assign zero = (rem_reg == REM_W'(1));

endmodule

// File: rtl/ram_rfsh_fill_ctrl.sv
// Background SRAM fill engine that writes one byte per Z80 refresh cycle.
// Optional build macro FILL_INC_PATTERN_EN adds the incrementing test pattern.
module ram_rfsh_fill_ctrl
    import ram1m_pkg::*;
#(
    parameter logic [3:0] SHADOW_BANK = SHADOW_BANK_DEF,
    parameter int         LEN_W       = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset_b_w,
    input  logic             rfsh_b,
    input  logic             mreq_b,
    input  logic             io_wr_stb,
    input  logic [2:0]       io_reg,
    input  logic [7:0]       io_data,
    input  logic             shadow_mode,
    output logic             fill_own,
    output logic             fill_ramcs0_b,
    output logic             fill_ramcs1_b,
    output logic             fill_ramwe_b,
    output logic [4:0]       fill_ramadrhi,
    output logic [LEN_W+7:0] fill_adr,
    output logic [7:0]       fill_data,
    output logic             fill_data_oe,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int ADR_W = LEN_W + 8;
    localparam int REM_W = LEN_W + 9;

    fill_state_t      state_reg;
    logic [7:0]       fill_byte_reg;
    logic [5:0]       blk_reg;
    logic [LEN_W-1:0] page_reg;
    logic [LEN_W-1:0] len_reg;
    logic             abort_pend_reg;
    logic             own_reg;
    logic             cs0_b_reg;
    logic             cs1_b_reg;
    logic             we_b_reg;
    logic             oe_reg;
    logic             done_reg;
    logic             err_reg;
`ifdef FILL_INC_PATTERN_EN
    logic             inc_reg;
`endif

    logic             cfg_wr;
    logic             cmd_wr;
    logic             cmd_start;
    logic             cmd_abort;
    logic             shadow_hit;
    logic             ctr_load;
    logic             ctr_step;
    logic             ctr_zero;
    logic [ADR_W-1:0] ctr_adr;
    logic [ADR_W-1:0] load_adr;
    logic [REM_W-1:0] load_rem;

    assign cfg_wr     = io_wr_stb && (state_reg == ST_IDLE);
    assign cmd_wr     = io_wr_stb && (io_reg == REG_CMD);
    assign cmd_abort  = cmd_wr && io_data[CMD_ABORT];
    assign cmd_start  = cmd_wr && io_data[CMD_START] && !io_data[CMD_ABORT];
    assign shadow_hit = shadow_mode &&
                        ({blk_reg[5], blk_reg[4:2]} == {1'b0, SHADOW_BANK[2:0]});

    assign ctr_load = (state_reg == ST_IDLE) && cmd_start && !shadow_hit;
    assign ctr_step = (state_reg == ST_HOLD);
    assign load_adr = {page_reg, 8'h00};
    // A programmed length of zero means a whole 16KB block.
    assign load_rem = {(len_reg == '0), len_reg, 8'h00};

    fill_addr_ctr #(
        .ADR_W(ADR_W),
        .REM_W(REM_W)
    ) u_ctr (
        .clk      (clk),
        .reset_b_w(reset_b_w),
        .load     (ctr_load),
        .step     (ctr_step),
        .load_adr (load_adr),
        .load_rem (load_rem),
        .adr      (ctr_adr),
        .zero     (ctr_zero)
    );

    always_ff @(posedge clk or negedge reset_b_w) begin
        if (!reset_b_w) begin
            state_reg      <= ST_IDLE;
            fill_byte_reg  <= '0;
            blk_reg        <= '0;
            page_reg       <= '0;
            len_reg        <= '0;
            abort_pend_reg <= 1'b0;
            own_reg        <= 1'b0;
            cs0_b_reg      <= 1'b1;
            cs1_b_reg      <= 1'b1;
            we_b_reg       <= 1'b1;
            oe_reg         <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
`ifdef FILL_INC_PATTERN_EN
            inc_reg        <= 1'b0;
`endif
        end else begin
            if (cfg_wr) begin
                case (io_reg)
                    REG_FILL: fill_byte_reg <= io_data;
                    REG_BLK:  blk_reg       <= io_data[5:0];
                    REG_PAGE: page_reg      <= io_data[LEN_W-1:0];
                    REG_LEN:  len_reg       <= io_data[LEN_W-1:0];
                    default:  ;
                endcase
            end

            case (state_reg)
                ST_IDLE: begin
                    if (cmd_start) begin
                        if (shadow_hit) begin
                            err_reg <= 1'b1;
                        end else begin
                            done_reg       <= 1'b0;
                            err_reg        <= 1'b0;
                            abort_pend_reg <= 1'b0;
`ifdef FILL_INC_PATTERN_EN
                            inc_reg        <= io_data[CMD_INC];
`endif
                            state_reg      <= ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    // Refresh must be seen released so each refresh yields one byte.
                    if (cmd_abort)   state_reg <= ST_IDLE;
                    else if (rfsh_b) state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cmd_abort) begin
                        state_reg <= ST_IDLE;
                    end else if (!rfsh_b && !mreq_b) begin
                        state_reg <= ST_WRITE;
                        own_reg   <= 1'b1;
                        cs0_b_reg <= blk_reg[5];
                        cs1_b_reg <= !blk_reg[5];
                        we_b_reg  <= 1'b0;
                        oe_reg    <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (cmd_abort) abort_pend_reg <= 1'b1;
                    state_reg <= ST_HOLD;
                    we_b_reg  <= 1'b1;
                end
                ST_HOLD: begin
                    own_reg   <= 1'b0;
                    cs0_b_reg <= 1'b1;
                    cs1_b_reg <= 1'b1;
                    oe_reg    <= 1'b0;
                    if (abort_pend_reg || cmd_abort) begin
                        state_reg <= ST_IDLE;
                    end else if (ctr_zero) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= ST_ARM;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign fill_own      = own_reg;
    assign fill_ramcs0_b = cs0_b_reg;
    assign fill_ramcs1_b = cs1_b_reg;
    assign fill_ramwe_b  = we_b_reg;
    assign fill_data_oe  = oe_reg;
    assign fill_ramadrhi = blk_reg[4:0];
    assign fill_adr      = ctr_adr;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = done_reg;
    assign err           = err_reg;
`ifdef FILL_INC_PATTERN_EN
    assign fill_data     = fill_byte_reg + (inc_reg ? ctr_adr[7:0] : 8'h00);
`else
    assign fill_data     = fill_byte_reg;
`endif

endmodule
